// File: rtl/pipe_core_pkg.sv
// Shared encodings and ALU operation set for the 4-stage integer core.
// Pure declarations: no latency, no flow control.
package pipe_core_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipe_regfile.sv
// NREGS x XLEN register file, 2 combinational read ports with write-through, 1 write port.
// Zero latency on reads; writes land at the clock edge; no backpressure. x0 reads 0.
module pipe_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  function automatic logic in_range(input logic [4:0] a);
    return 32'(a) < NREGS;
  endfunction

  assign wr_en = we && (waddr != 5'd0) && in_range(waddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  // Same-cycle write is visible to the reader: covers distance-2 dependencies.
  assign rdata1 = (raddr1 == 5'd0 || !in_range(raddr1)) ? '0 :
                  (wr_en && waddr == raddr1) ? wdata : regs[raddr1[AW-1:0]];
  assign rdata2 = (raddr2 == 5'd0 || !in_range(raddr2)) ? '0 :
                  (wr_en && waddr == raddr2) ? wdata : regs[raddr2[AW-1:0]];

endmodule

// File: rtl/pipe_core_top.sv
// 4-stage in-order integer core (F/D/E/W); an instruction fetched in cycle t retires in t+3.
// No backpressure: imem_valid=0 holds PC and injects a bubble; data hazards never stall.
module pipe_core_top
  import pipe_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic            retire_we,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic [63:0]     instret
);

  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifid_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic            we;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    alu_op_e         op;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_dat;
    logic [XLEN-1:0] rs2_dat;
  } idex_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] dat;
  } exwb_t;

  logic [XLEN-1:0] pc;
  ifid_t           ifid;
  idex_t           idex, dec;
  exwb_t           exwb;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_u, rf_rd1, rf_rd2;
  logic            legal, use1, use2;
  logic [XLEN-1:0] opa, opb, alu_res;
  logic [SHW-1:0]  shamt;

  function automatic logic reg_ok(input logic [4:0] r);
    return 32'(r) < NREGS;
  endfunction

  assign opcode = ifid.instr[6:0];
  assign rd     = ifid.instr[11:7];
  assign f3     = ifid.instr[14:12];
  assign rs1    = ifid.instr[19:15];
  assign rs2    = ifid.instr[24:20];
  assign f7     = ifid.instr[31:25];
  assign imm_i  = XLEN'($signed(ifid.instr[31:20]));
  assign imm_u  = XLEN'($signed({ifid.instr[31:12], 12'b0}));

  pipe_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (exwb.we),
    .waddr  (exwb.rd),
    .wdata  (exwb.dat)
  );

  // Decode; anything not recognised becomes a retiring NOP with we=0.
  always_comb begin
    dec         = '0;
    legal       = 1'b0;
    use1        = 1'b0;
    use2        = 1'b0;
    dec.vld     = ifid.vld;
    dec.pc      = ifid.pc;
    dec.rd      = rd;
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.rs1_dat = rf_rd1;
    dec.rs2_dat = rf_rd2;
    case (opcode)
      OPC_OP: begin
        use1   = 1'b1;
        use2   = 1'b1;
        legal  = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        dec.op = f3_to_op(f3, f7[5]);
      end
      OPC_OPIMM: begin
        use1        = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec.op      = f3_to_op(f3, (f3 == F3_SR) && f7[5]);
        legal       = (f3 == F3_SLL) ? (f7 == F7_BASE) :
                      (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
      end
      OPC_LUI: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
        dec.op      = ALU_PASSB;
        legal       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if ((use1 && !reg_ok(rs1)) || (use2 && !reg_ok(rs2)) || !reg_ok(rd)) legal = 1'b0;
    dec.we = ifid.vld && legal && (rd != 5'd0);
  end

  // Distance-1 forwarding from the instruction currently in W.
  assign opa   = (exwb.we && exwb.rd == idex.rs1 && idex.rs1 != 5'd0) ? exwb.dat : idex.rs1_dat;
  assign opb   = idex.use_imm ? idex.imm :
                 (exwb.we && exwb.rd == idex.rs2 && idex.rs2 != 5'd0) ? exwb.dat : idex.rs2_dat;
  assign shamt = opb[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (idex.op)
      ALU_ADD:  alu_res = opa + opb;
      ALU_SUB:  alu_res = opa - opb;
      ALU_SLL:  alu_res = opa << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(opa) < $signed(opb));
      ALU_SLTU: alu_res = XLEN'(opa < opb);
      ALU_XOR:  alu_res = opa ^ opb;
      ALU_SRL:  alu_res = opa >> shamt;
      ALU_SRA:  alu_res = $signed(opa) >>> shamt;
      ALU_OR:   alu_res = opa | opb;
      ALU_AND:  alu_res = opa & opb;
      default:  alu_res = opb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ifid    <= '0;
      idex    <= '0;
      exwb    <= '0;
      instret <= '0;
    end else begin
      if (imem_valid) begin
        ifid.vld   <= 1'b1;
        ifid.pc    <= pc;
        ifid.instr <= imem_rdata;
        pc         <= pc + XLEN'(4);
      end else begin
        ifid.vld   <= 1'b0;
      end
      idex     <= dec;
      exwb.vld <= idex.vld;
      exwb.pc  <= idex.pc;
      exwb.we  <= idex.we;
      exwb.rd  <= idex.rd;
      exwb.dat <= alu_res;
      instret  <= instret + 64'(exwb.vld);
    end
  end

  assign imem_addr    = pc;
  assign retire_valid = exwb.vld;
  assign retire_pc    = exwb.pc;
  assign retire_we    = exwb.we;
  assign retire_rd    = exwb.rd;
  assign retire_data  = exwb.dat;

endmodule

// File: tb/tb_pipe_core_top.sv
// Scoreboard bench: the driver runs an instruction-level reference model and queues expected
// retirements; a monitor pops and compares on every retire_valid.
module tb_pipe_core_top;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_valid, retire_valid, retire_we;
  logic [31:0] imem_addr, imem_rdata, retire_pc, retire_data;
  logic [4:0]  retire_rd;
  logic [63:0] instret;

  logic        reset16, imem_valid16, retire_valid16, retire_we16;
  logic [31:0] imem_addr16, imem_rdata16, retire_pc16, retire_data16;
  logic [4:0]  retire_rd16;
  logic [63:0] instret16;

  pipe_core_top dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_we(retire_we), .retire_rd(retire_rd), .retire_data(retire_data),
    .instret(instret)
  );

  pipe_core_top #(.NREGS(16)) dut16 (
    .clk(clk), .reset(reset16), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16),
    .imem_valid(imem_valid16), .retire_valid(retire_valid16), .retire_pc(retire_pc16),
    .retire_we(retire_we16), .retire_rd(retire_rd16), .retire_data(retire_data16),
    .instret(instret16)
  );

  typedef struct {
    logic [31:0] pc;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] R [32];
  logic [31:0] pc_m;
  int          cyc = 0;
  int          n_cmp = 0, n_err = 0, n_ret = 0, n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] i_t(input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  // Architectural semantics of one instruction against the model register array.
  task automatic iss(input logic [31:0] ins, output bit we, output logic [4:0] rd,
                     output logic [31:0] v);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, imm;
    bit          ok, alt, base, is_op, is_imm;
    int          sh;
    opc = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12]; rd = ins[11:7];
    a = R[ins[19:15]]; b = R[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    alt = (f7 == 7'h20); base = (f7 == 7'h00);
    is_op = (opc == 7'b0110011); is_imm = (opc == 7'b0010011);
    ok = 1'b1; v = 32'h0;
    if (is_op || is_imm) begin
      if (is_imm) b = imm;
      sh = int'(b[4:0]);
      if (is_op && !base && !(alt && (f3 == 3'd0 || f3 == 3'd5))) ok = 1'b0;
      if (is_imm && f3 == 3'd1 && !base) ok = 1'b0;
      if (is_imm && f3 == 3'd5 && !base && !alt) ok = 1'b0;
      case (f3)
        3'd0: v = (is_op && alt) ? a - b : a + b;
        3'd1: v = a << sh;
        3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: v = (a < b) ? 32'd1 : 32'd0;
        3'd4: v = a ^ b;
        3'd5: v = alt ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: v = a | b;
        default: v = a & b;
      endcase
    end else if (opc == 7'b0110111) begin
      v = {ins[31:12], 12'h000};
    end else begin
      ok = 1'b0;
    end
    we = ok && (rd != 5'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    int          k, s;
    r = $urandom;
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    s = $urandom_range(0, 5);
    f7 = (s == 4) ? 7'h20 : (s == 5) ? r[31:25] : 7'h00;
    k = $urandom_range(0, 9);
    if (k < 4) return r_t(f7, f3, rd, rs1, rs2);
    if (k < 8) return i_t(f3, rd, rs1, (f3 == 3'd1 || f3 == 3'd5) ? {f7, r[24:20]} : r[11:0]);
    if (k == 8) return lui(rd, r[19:0]);
    return {r[31:7], 7'b1100011};
  endfunction

  // Each driver task starts at a falling edge and ends at the next one.
  task automatic issue_raw(input logic [31:0] ins, input bit we, input logic [4:0] rd,
                           input logic [31:0] d);
    exp_t e;
    chk("imem_addr", imem_addr, pc_m);
    imem_valid = 1'b1;
    imem_rdata = ins;
    e.pc = pc_m; e.we = we; e.rd = rd; e.dat = d; e.cyc = cyc + 3;
    sbq.push_back(e);
    if (we) R[rd] = d;
    pc_m += 32'd4;
    n_acc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins);
    bit          we;
    logic [4:0]  rd;
    logic [31:0] d;
    iss(ins, we, rd, d);
    issue_raw(ins, we, rd, d);
  endtask

  task automatic bubble();
    chk("imem_addr_hold", imem_addr, pc_m);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_valid = 1'b0;
    for (int i = 0; i < 32; i++) R[i] = 32'h0;
    pc_m = 32'h0;
    sbq.delete();
    n_ret = 0;
    n_acc = 0;
    @(negedge clk);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retire_we", retire_we, 0);
    chk("rst_retire_rd", retire_rd, 0);
    chk("rst_retire_pc", retire_pc, 0);
    chk("rst_retire_data", retire_data, 0);
    chk("rst_instret", instret, 0);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (retire_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_retire: pc 0x%0h, expected no retirement", retire_pc);
        end else begin
          e = sbq.pop_front();
          chk("retire_pc", retire_pc, e.pc);
          chk("retire_we", retire_we, e.we);
          if (e.we) begin
            chk("retire_rd", retire_rd, e.rd);
            chk("retire_data", retire_data, e.dat);
          end
          chk("retire_cycle", cyc, e.cyc);
          chk("instret_run", instret, n_ret);
          n_ret++;
        end
      end
    end
  end

  logic [31:0] prog16 [3];
  bit          we16 [3];
  logic [4:0]  rd16 [3];

  initial begin : driver
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0;
    reset16 = 1'b1; imem_valid16 = 1'b0; imem_rdata16 = 32'h0;
    pc_m = 32'h0;
    for (int i = 0; i < 32; i++) R[i] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    issue_raw(i_t(3'd0, 5'd1, 5'd0, 12'd5), 1'b1, 5'd1, 32'd5);
    issue_raw(i_t(3'd0, 5'd1, 5'd0, 12'd5), 1'b1, 5'd1, 32'd5);
    issue_raw(i_t(3'd0, 5'd2, 5'd1, 12'd3), 1'b1, 5'd2, 32'd8);
    issue_raw(r_t(7'h20, 3'd0, 5'd3, 5'd2, 5'd1), 1'b1, 5'd3, 32'd3);

    issue_raw(i_t(3'd0, 5'd1, 5'd0, 12'hFF8), 1'b1, 5'd1, 32'hFFFF_FFF8);
    issue_raw(i_t(3'd0, 5'd0, 5'd0, 12'h000), 1'b0, 5'd0, 32'h0);
    issue_raw(i_t(3'd5, 5'd2, 5'd1, {7'h20, 5'd1}), 1'b1, 5'd2, 32'hFFFF_FFFC);
    issue_raw(i_t(3'd5, 5'd3, 5'd1, {7'h00, 5'd28}), 1'b1, 5'd3, 32'h0000_000F);

    issue_raw(i_t(3'd0, 5'd7, 5'd0, 12'd1), 1'b1, 5'd7, 32'd1);
    bubble();
    bubble();
    issue_raw(i_t(3'd0, 5'd8, 5'd7, 12'd1), 1'b1, 5'd8, 32'd2);

    issue_raw(i_t(3'd0, 5'd0, 5'd0, 12'd7), 1'b0, 5'd0, 32'h0);
    issue_raw(r_t(7'h00, 3'd0, 5'd4, 5'd0, 5'd0), 1'b1, 5'd4, 32'h0);
    issue_raw(lui(5'd5, 20'hABCDE), 1'b1, 5'd5, 32'hABCD_E000);
    issue_raw(i_t(3'd3, 5'd6, 5'd0, 12'hFFF), 1'b1, 5'd6, 32'd1);

    issue_raw(i_t(3'd0, 5'd1, 5'd0, 12'hFFF), 1'b1, 5'd1, 32'hFFFF_FFFF);
    issue_raw(r_t(7'h00, 3'd2, 5'd2, 5'd1, 5'd0), 1'b1, 5'd2, 32'd1);
    issue_raw(r_t(7'h00, 3'd3, 5'd3, 5'd1, 5'd0), 1'b1, 5'd3, 32'd0);
    issue_raw(r_t(7'h01, 3'd0, 5'd4, 5'd1, 5'd1), 1'b0, 5'd4, 32'h0);
    issue_raw(i_t(3'd1, 5'd5, 5'd1, {7'h20, 5'd3}), 1'b0, 5'd5, 32'h0);
    repeat (4) bubble();
    chk("instret_directed", instret, n_acc);

    // Reset lands while three instructions are in flight.
    issue_raw(i_t(3'd0, 5'd1, 5'd0, 12'd5), 1'b1, 5'd1, 32'd5);
    issue_raw(i_t(3'd0, 5'd2, 5'd1, 12'd1), 1'b1, 5'd2, 32'd6);
    issue_raw(i_t(3'd0, 5'd3, 5'd2, 12'd1), 1'b1, 5'd3, 32'd7);
    do_reset();
    issue_raw(i_t(3'd0, 5'd4, 5'd1, 12'd1), 1'b1, 5'd4, 32'd1);
    issue_raw(i_t(3'd0, 5'd5, 5'd2, 12'd2), 1'b1, 5'd5, 32'd2);
    issue_raw(i_t(3'd0, 5'd6, 5'd3, 12'd3), 1'b1, 5'd6, 32'd3);
    repeat (4) bubble();
    chk("instret_after_reset", instret, 3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bubble();
      else issue(rand_instr());
    end
    repeat (5) bubble();
    chk("scoreboard_drained", sbq.size(), 0);
    chk("instret_final", instret, n_acc);

    prog16[0] = i_t(3'd0, 5'd20, 5'd0, 12'd1);  we16[0] = 1'b0; rd16[0] = 5'd20;
    prog16[1] = i_t(3'd0, 5'd1, 5'd20, 12'd1);  we16[1] = 1'b0; rd16[1] = 5'd1;
    prog16[2] = i_t(3'd0, 5'd15, 5'd0, 12'd9);  we16[2] = 1'b1; rd16[2] = 5'd15;
    chk("n16_rst_addr", imem_addr16, 0);
    chk("n16_rst_valid", retire_valid16, 0);
    chk("n16_rst_instret", instret16, 0);
    reset16 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k >= 3) begin
        chk("n16_retire_valid", retire_valid16, 1);
        chk("n16_retire_we", retire_we16, we16[k-3]);
        chk("n16_retire_rd", retire_rd16, rd16[k-3]);
        chk("n16_retire_pc", retire_pc16, 32'(4 * (k - 3)));
        if (we16[k-3]) chk("n16_retire_data", retire_data16, 9);
      end
      if (k < 3) begin
        imem_valid16 = 1'b1;
        imem_rdata16 = prog16[k];
      end else begin
        imem_valid16 = 1'b0;
      end
      @(negedge clk);
    end
    chk("n16_instret", instret16, 3);
    chk("n16_imem_addr", imem_addr16, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
